// File: rtl/ifu_pcgen_if.sv
// Fetch-side and decode-side bundle of the ifu_pcgen fetch sequencer.
// The master modport is the sequencer; slave is the IFU/IDU/EXU environment.
interface ifu_pcgen_if;
  logic [63:0] ifetch_pc;
  logic        ifetch_req;
  logic        IFU_vld;
  logic [63:0] IFU_pc;
  logic [63:0] IFU_inst;
  logic        redirect_vld;
  logic [63:0] redirect_pc;
  logic        id_vld;
  logic [63:0] id_pc;
  logic [31:0] id_inst;
  logic        id_ready;
  logic [63:0] fetch_cnt;
  logic        proto_err;
  logic        fetch_misalign;

  modport master (
    output ifetch_pc, ifetch_req, id_vld, id_pc, id_inst, fetch_cnt, proto_err, fetch_misalign,
    input  IFU_vld, IFU_pc, IFU_inst, redirect_vld, redirect_pc, id_ready
  );

  modport slave (
    input  ifetch_pc, ifetch_req, id_vld, id_pc, id_inst, fetch_cnt, proto_err, fetch_misalign,
    output IFU_vld, IFU_pc, IFU_inst, redirect_vld, redirect_pc, id_ready
  );
endinterface

// File: rtl/ifu_pcgen.sv
// Fetch sequencer: one outstanding fetch, one held instruction toward decode, EXU redirects.
// Optional macro IFU_MISALIGN_CHECK_EN traps on misaligned redirect targets instead of aligning them.
module ifu_pcgen #(
  parameter logic [63:0] RESET_PC    = 64'h8000_0000,
  parameter int unsigned BOOT_CYCLES = 10
) (
  input logic         clk,
  input logic         rst,
  ifu_pcgen_if.master bus
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_WAIT,
    S_HOLD,
`ifdef IFU_MISALIGN_CHECK_EN
    S_DRAIN,
    S_TRAP
`else
    S_DRAIN
`endif
  } state_e;

  localparam logic [5:0] BOOT_LAST = 6'(BOOT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [5:0]  bootCnt_q, bootCnt_d;
  logic [63:0] reqPc_q, reqPc_d;
  logic        req_q, req_d;
  logic        idVld_q, idVld_d;
  logic [63:0] idPc_q, idPc_d;
  logic [31:0] idInst_q, idInst_d;
  logic [63:0] fetchCnt_q, fetchCnt_d;
  logic        protoErr_q, protoErr_d;
  logic        misalign_q, misalign_d;
  logic [63:0] redirTgt;
  logic        redirBad;

`ifdef IFU_MISALIGN_CHECK_EN
  assign redirTgt = bus.redirect_pc;
  assign redirBad = bus.redirect_vld && (bus.redirect_pc[1:0] != 2'b00);
`else
  assign redirTgt = {bus.redirect_pc[63:2], 2'b00};
  assign redirBad = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      bootCnt_q  <= '0;
      reqPc_q    <= RESET_PC;
      req_q      <= 1'b0;
      idVld_q    <= 1'b0;
      idPc_q     <= '0;
      idInst_q   <= '0;
      fetchCnt_q <= '0;
      protoErr_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      bootCnt_q  <= bootCnt_d;
      reqPc_q    <= reqPc_d;
      req_q      <= req_d;
      idVld_q    <= idVld_d;
      idPc_q     <= idPc_d;
      idInst_q   <= idInst_d;
      fetchCnt_q <= fetchCnt_d;
      protoErr_q <= protoErr_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    bootCnt_d  = bootCnt_q;
    reqPc_d    = reqPc_q;
    req_d      = 1'b0;
    idVld_d    = idVld_q;
    idPc_d     = idPc_q;
    idInst_d   = idInst_q;
    fetchCnt_d = fetchCnt_q;
    protoErr_d = protoErr_q;
    misalign_d = misalign_q;

    if (bus.redirect_vld) pc_d = redirTgt;
    // id_vld is only ever high in HOLD, so any handshake counts, even one that loses to a redirect
    if (idVld_q && bus.id_ready) fetchCnt_d = fetchCnt_q + 64'd1;

    case (state_q)
      S_BOOT: begin
        if (bus.IFU_vld) protoErr_d = 1'b1;
        bootCnt_d = bootCnt_q + 6'd1;
        if (redirBad) begin
          misalign_d = 1'b1;
`ifdef IFU_MISALIGN_CHECK_EN
          state_d    = S_TRAP;
`endif
        end else if (bootCnt_q == BOOT_LAST) begin
          req_d   = 1'b1;
          reqPc_d = pc_d;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.redirect_vld) begin
          if (redirBad) begin
            misalign_d = 1'b1;
`ifdef IFU_MISALIGN_CHECK_EN
            state_d    = bus.IFU_vld ? S_TRAP : S_DRAIN;
`endif
          end else if (bus.IFU_vld) begin
            req_d   = 1'b1;
            reqPc_d = redirTgt;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (bus.IFU_vld) begin
          idVld_d  = 1'b1;
          idPc_d   = bus.IFU_pc;
          idInst_d = bus.IFU_inst[31:0];
          pc_d     = bus.IFU_pc + 64'd4;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.IFU_vld) protoErr_d = 1'b1;
        if (bus.redirect_vld) begin
          idVld_d = 1'b0;
          if (redirBad) begin
            misalign_d = 1'b1;
`ifdef IFU_MISALIGN_CHECK_EN
            state_d    = S_TRAP;
`endif
          end else begin
            req_d   = 1'b1;
            reqPc_d = redirTgt;
            state_d = S_WAIT;
          end
        end else if (bus.id_ready) begin
          idVld_d = 1'b0;
          req_d   = 1'b1;
          reqPc_d = pc_q;
          state_d = S_WAIT;
        end
      end
      S_DRAIN: begin
        if (bus.redirect_vld) misalign_d = redirBad;
        if (bus.IFU_vld) begin
          if (misalign_d) begin
`ifdef IFU_MISALIGN_CHECK_EN
            state_d = S_TRAP;
`endif
          end else begin
            req_d   = 1'b1;
            reqPc_d = pc_d;
            state_d = S_WAIT;
          end
        end
      end
`ifdef IFU_MISALIGN_CHECK_EN
      S_TRAP: begin
        if (bus.IFU_vld) protoErr_d = 1'b1;
        if (bus.redirect_vld && !redirBad) begin
          misalign_d = 1'b0;
          req_d      = 1'b1;
          reqPc_d    = redirTgt;
          state_d    = S_WAIT;
        end
      end
`endif
      default: state_d = S_BOOT;
    endcase
  end

  assign bus.ifetch_pc  = reqPc_q;
  assign bus.ifetch_req = req_q;
  assign bus.id_vld     = idVld_q;
  assign bus.id_pc      = idPc_q;
  assign bus.id_inst    = idInst_q;
  assign bus.fetch_cnt  = fetchCnt_q;
  assign bus.proto_err  = protoErr_q;
`ifdef IFU_MISALIGN_CHECK_EN
  assign bus.fetch_misalign = misalign_q;
`else
  assign bus.fetch_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_pcgen.sv
// Directed bench for ifu_pcgen: boot timing, fetch/handshake flow, stalls, redirects, reset abort, misalign.
// Expected values are hand-computed; IFU_MISALIGN_CHECK_EN selects the trap or aligned-target expectations.
module tb_ifu_pcgen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ifu_pcgen_if bus();

  ifu_pcgen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic vld, input logic [63:0] pc, input logic [31:0] inst,
                               input logic rvld, input logic [63:0] rpc);
    bus.IFU_vld      = vld;
    bus.IFU_pc       = pc;
    bus.IFU_inst     = {32'hDEAD_BEEF, inst};
    bus.redirect_vld = rvld;
    bus.redirect_pc  = rpc;
  endtask

  // Counts cycles until ifetch_req is seen; a timeout shows up as a wrong count.
  task automatic waitReq(output int n);
    n = 0;
    while (bus.ifetch_req !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  // Entered in the cycle the request pulse is visible; IFU answers two cycles later.
  task automatic doFetch(input logic [63:0] pc, input logic [31:0] inst, input int stall,
                         input logic [63:0] cnt);
    checkOutput("req_pulse", {63'd0, bus.ifetch_req}, 64'd1);
    checkOutput("req_pc", bus.ifetch_pc, pc);
    tick();
    checkOutput("req_single", {63'd0, bus.ifetch_req}, 64'd0);
    tick();
    applyStimulus(1'b1, pc, inst, 1'b0, 64'd0);
    bus.id_ready = (stall == 0);
    tick();
    applyStimulus(1'b0, 64'd0, 32'd0, 1'b0, 64'd0);
    checkOutput("id_vld_set", {63'd0, bus.id_vld}, 64'd1);
    checkOutput("id_pc", bus.id_pc, pc);
    checkOutput("id_inst", {32'd0, bus.id_inst}, {32'd0, inst});
    for (int i = 0; i < stall; i++) begin
      tick();
      checkOutput("stall_vld", {63'd0, bus.id_vld}, 64'd1);
      checkOutput("stall_pc", bus.id_pc, pc);
      checkOutput("stall_inst", {32'd0, bus.id_inst}, {32'd0, inst});
      checkOutput("stall_noreq", {63'd0, bus.ifetch_req}, 64'd0);
      checkOutput("stall_cnt", bus.fetch_cnt, cnt - 64'd1);
    end
    bus.id_ready = 1'b1;
    tick();
    checkOutput("hs_vld_clr", {63'd0, bus.id_vld}, 64'd0);
    checkOutput("hs_cnt", bus.fetch_cnt, cnt);
  endtask

  initial begin
    int n;
    logic [63:0] lastPc;
    applyStimulus(1'b0, 64'd0, 32'd0, 1'b0, 64'd0);
    bus.id_ready = 1'b1;

    // Reset state
    tick();
    tick();
    checkOutput("rst_req", {63'd0, bus.ifetch_req}, 64'd0);
    checkOutput("rst_ifpc", bus.ifetch_pc, 64'h8000_0000);
    checkOutput("rst_idvld", {63'd0, bus.id_vld}, 64'd0);
    checkOutput("rst_idpc", bus.id_pc, 64'd0);
    checkOutput("rst_idinst", {32'd0, bus.id_inst}, 64'd0);
    checkOutput("rst_cnt", bus.fetch_cnt, 64'd0);
    checkOutput("rst_perr", {63'd0, bus.proto_err}, 64'd0);
    checkOutput("rst_mis", {63'd0, bus.fetch_misalign}, 64'd0);
    rst = 1'b0;

    // Boot delay and three sequential fetches, the second stalled for five cycles
    waitReq(n);
    checkOutput("boot_cycles", 64'(n), 64'd10);
    doFetch(64'h8000_0000, 32'h0000_0013, 0, 64'd1);
    doFetch(64'h8000_0004, 32'h0010_0073, 5, 64'd2);
    doFetch(64'h8000_0008, 32'h0000_0093, 0, 64'd3);
    checkOutput("seq_next_pc", bus.ifetch_pc, 64'h8000_000C);

    // Redirect while waiting, stale response three cycles later
    tick();
    applyStimulus(1'b0, 64'd0, 32'd0, 1'b1, 64'h8000_1000);
    tick();
    applyStimulus(1'b0, 64'd0, 32'd0, 1'b0, 64'd0);
    checkOutput("drain_noreq", {63'd0, bus.ifetch_req}, 64'd0);
    tick();
    tick();
    applyStimulus(1'b1, 64'h8000_000C, 32'h1111_1111, 1'b0, 64'd0);
    tick();
    applyStimulus(1'b0, 64'd0, 32'd0, 1'b0, 64'd0);
    checkOutput("drain_idvld", {63'd0, bus.id_vld}, 64'd0);
    checkOutput("drain_perr", {63'd0, bus.proto_err}, 64'd0);
    doFetch(64'h8000_1000, 32'h2222_2222, 0, 64'd4);

    // Redirect coinciding with the response
    tick();
    tick();
    applyStimulus(1'b1, 64'h8000_1004, 32'h3333_3333, 1'b1, 64'h8000_2000);
    tick();
    applyStimulus(1'b0, 64'd0, 32'd0, 1'b0, 64'd0);
    checkOutput("same_idvld", {63'd0, bus.id_vld}, 64'd0);
    checkOutput("same_perr", {63'd0, bus.proto_err}, 64'd0);
    doFetch(64'h8000_2000, 32'h4444_4444, 0, 64'd5);

    // Asynchronous reset mid-fetch, then a late response during boot
    tick();
    rst = 1'b1;
    #1;
    checkOutput("arst_ifpc", bus.ifetch_pc, 64'h8000_0000);
    checkOutput("arst_cnt", bus.fetch_cnt, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    applyStimulus(1'b1, 64'h8000_2004, 32'h5555_5555, 1'b0, 64'd0);
    tick();
    applyStimulus(1'b0, 64'd0, 32'd0, 1'b0, 64'd0);
    checkOutput("late_perr", {63'd0, bus.proto_err}, 64'd1);
    checkOutput("late_idvld", {63'd0, bus.id_vld}, 64'd0);
    waitReq(n);
    checkOutput("reboot_cycles", 64'(n), 64'd8);
    checkOutput("reboot_pc", bus.ifetch_pc, 64'h8000_0000);

    // Misaligned redirect while waiting
    tick();
    applyStimulus(1'b0, 64'd0, 32'd0, 1'b1, 64'h8000_0002);
    tick();
    applyStimulus(1'b0, 64'd0, 32'd0, 1'b0, 64'd0);
    checkOutput("mis_noreq", {63'd0, bus.ifetch_req}, 64'd0);
    tick();
    applyStimulus(1'b1, 64'h8000_0000, 32'h6666_6666, 1'b0, 64'd0);
    tick();
    applyStimulus(1'b0, 64'd0, 32'd0, 1'b0, 64'd0);
`ifdef IFU_MISALIGN_CHECK_EN
    checkOutput("trap_flag", {63'd0, bus.fetch_misalign}, 64'd1);
    checkOutput("trap_noreq", {63'd0, bus.ifetch_req}, 64'd0);
    tick();
    checkOutput("trap_still", {63'd0, bus.ifetch_req}, 64'd0);
    applyStimulus(1'b0, 64'd0, 32'd0, 1'b1, 64'h8000_0010);
    tick();
    applyStimulus(1'b0, 64'd0, 32'd0, 1'b0, 64'd0);
    checkOutput("untrap_flag", {63'd0, bus.fetch_misalign}, 64'd0);
    checkOutput("untrap_req", {63'd0, bus.ifetch_req}, 64'd1);
    checkOutput("untrap_pc", bus.ifetch_pc, 64'h8000_0010);
    lastPc = 64'h8000_0010;
`else
    checkOutput("align_flag", {63'd0, bus.fetch_misalign}, 64'd0);
    checkOutput("align_req", {63'd0, bus.ifetch_req}, 64'd1);
    checkOutput("align_pc", bus.ifetch_pc, 64'h8000_0000);
    lastPc = 64'h8000_0000;
`endif

    // Redirect in HOLD with a same-cycle handshake: instruction dropped but still counted
    tick();
    tick();
    applyStimulus(1'b1, lastPc, 32'h7777_7777, 1'b0, 64'd0);
    bus.id_ready = 1'b0;
    tick();
    applyStimulus(1'b0, 64'd0, 32'd0, 1'b0, 64'd0);
    checkOutput("hold_vld", {63'd0, bus.id_vld}, 64'd1);
    checkOutput("hold_pc", bus.id_pc, lastPc);
    bus.id_ready = 1'b1;
    applyStimulus(1'b0, 64'd0, 32'd0, 1'b1, 64'h8000_3000);
    tick();
    applyStimulus(1'b0, 64'd0, 32'd0, 1'b0, 64'd0);
    checkOutput("hredir_vld", {63'd0, bus.id_vld}, 64'd0);
    checkOutput("hredir_req", {63'd0, bus.ifetch_req}, 64'd1);
    checkOutput("hredir_pc", bus.ifetch_pc, 64'h8000_3000);
    checkOutput("hredir_cnt", bus.fetch_cnt, 64'd1);
    checkOutput("perr_sticky", {63'd0, bus.proto_err}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
